// File: rtl/lsu_mem_port.sv
// MEM-stage load/store controller driving a word-addressed data memory
// (async read, sync write). Optional misalignment trapping: LSU_MISALIGN_TRAP_EN.
module lsu_mem_port #(
  parameter int DEPTH = 100,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] mem_a,
  output logic [31:0]   mem_wd,
  output logic          mem_we,
  input  logic [31:0]   mem_rd
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  logic [1:0]  state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        bad_f3;
  logic        out_of_range;
  logic        misaligned;
  logic        err;
  logic        sw_now;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext;
  logic [31:0] merged;

  // Request classification, evaluated on the latched request during ACC.
  always_comb begin
    bad_f3       = we_q ? (f3_q > 3'b010) : (f3_q == 3'b011 || f3_q[2:1] == 2'b11);
    out_of_range = addr_q[31:2] >= DEPTH_W;
`ifdef LSU_MISALIGN_TRAP_EN
    case (f3_q[1:0])
      2'b01:   misaligned = addr_q[0];
      2'b10:   misaligned = |addr_q[1:0];
      default: misaligned = 1'b0;
    endcase
`else
    misaligned = 1'b0;
`endif
    err    = bad_f3 | out_of_range | misaligned;
    sw_now = (state == S_ACC) && we_q && !err && (f3_q == 3'b010);
  end

  // Little-endian lane extraction and sign/zero extension for loads.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    byte_sel = mem_rd[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    ext      = '0;
    case (f3_q)
      3'b000:  ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ext = {{16{half_sel[15]}}, half_sel};
      3'b010:  ext = mem_rd;
      3'b100:  ext = {24'b0, byte_sel};
      3'b101:  ext = {16'b0, half_sel};
      default: ext = '0;
    endcase
  end

  // Read-modify-write merge for SB/SH.
  always_comb begin
    merged = merge_q;
    if (f3_q[1:0] == 2'b00)
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      case (state)
        S_IDLE: if (req_valid) begin
          we_q    <= req_we;
          f3_q    <= req_funct3;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          rdata_q <= '0;
          err_q   <= 1'b0;
          state   <= S_ACC;
        end
        S_ACC: begin
          err_q   <= err;
          rdata_q <= (!we_q && !err) ? ext : '0;
          merge_q <= mem_rd;
          state   <= (we_q && !err && !f3_q[1]) ? S_WR : S_RESP;
        end
        S_WR:    state <= S_RESP;
        default: if (resp_ready) state <= S_IDLE;
      endcase
    end
  end

  // Gating with rst_n keeps the handshake and write strobe low the instant reset asserts.
  assign req_ready  = rst_n && (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_a      = (state == S_IDLE) ? '0 : addr_q[AW+1:2];
  assign mem_we     = rst_n && (sw_now || (state == S_WR));
  assign mem_wd     = (state == S_WR) ? merged : (sw_now ? wdata_q : '0);

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store access controller for the MEM stage of the five-stage RISC-V pipeline; it is the initiator side of the data-memory port. It accepts one load or store request at a time from the pipeline and drives the word-addressed data memory's address, write-data and write-enable lines. That memory has an asynchronous read path and a synchronous, enable-gated write. The block performs read-modify-write for byte and halfword stores, and sign or zero extension for loads. It holds the pipeline off through a ready/valid handshake.

## Interface
- DEPTH, 100: number of 32-bit words in the attached memory; word index ≥ DEPTH is out of range
- AW, 14: memory word-address width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  in  32  byte address
- req_wdata  in  32  store data (right-aligned)
- resp_valid  out  1  response available
- resp_ready  in  1  pipeline consumes response
- resp_rdata  out  32  extended load data (0 for stores)
- resp_err  out  1  request rejected (no memory write occurred)
- mem_a  out  AW  word address to memory
- mem_wd  out  32  write data to memory
- mem_we  out  1  write enable to memory
- mem_rd  in  32  asynchronous read data from memory

## Operation
- States: IDLE, ACC, WR, RESP.
- IDLE: req_ready=1. On req_valid, latch the request and go to ACC.
- ACC: mem_a = latched addr[AW+1:2].
  - Erroneous request: set err and go to RESP with no write.
  - Load: capture the extended mem_rd into resp_rdata and go to RESP.
  - SW: mem_we=1, mem_wd=wdata, go to RESP.
  - SB/SH: capture mem_rd into the merge register, go to WR.
- WR: mem_we=1; mem_wd = merge register with the selected lane(s) replaced by wdata[7:0] or wdata[15:0]; go to RESP.
- RESP: resp_valid=1, holding rdata and err stable until resp_ready; then go to IDLE.
- Lane selection is little-endian: the byte is chosen by addr[1:0]; the halfword by addr[1].
- LB and LH sign-extend; LBU and LHU zero-extend.
- Error conditions:
  - Illegal funct3 (loads: 011, 11x; stores: any value other than 000/001/010).
  - Word index ≥ DEPTH.
  - Misalignment (see Configuration).
- mem_we is asserted only in the single write cycle (ACC for SW, WR for SB/SH); it is never asserted otherwise.

## Timing
- Reset values: req_ready=0 while rst_n is low, then 1 (IDLE). resp_valid=0, resp_rdata=0, resp_err=0, mem_a=0, mem_wd=0, mem_we=0.
- Latency from the accept edge to the first resp_valid cycle:
  - Load, SW, or error: 2 cycles.
  - SB/SH: 3 cycles.
- The memory write lands on the clk edge that ends the write cycle.
- mem_a is held constant from ACC through RESP and is 0 in IDLE.
- req_valid in any non-IDLE state is ignored (not latched).
- resp_ready low in RESP: the block stays in RESP indefinitely.
- Back-to-back requests: the next accept happens at the earliest one cycle after the RESP handshake.
- Reset mid-operation drops mem_we immediately and returns the block to IDLE. A store whose write edge has not occurred is aborted; the memory is unchanged.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - Misaligned LH/LHU/SH (addr[0]=1) or LW/SW (addr[1:0]≠0) sets resp_err=1.
  - No memory write occurs; resp_rdata=0.
- Not defined:
  - Misalignment is not checked; the offending low address bits are ignored (halfword uses addr[1], word uses the word index only).
  - resp_err reflects only the illegal-funct3 and range conditions.

## Test plan
- Memory word 0 preloaded with 0x9F5D4A6E:
  - LB @0x1 -> resp_rdata 0x0000004A.
  - LB @0x3 -> 0xFFFFFF9F.
  - LBU @0x3 -> 0x0000009F.
  - LW @0x0 -> 0x9F5D4A6E, with resp_valid 2 cycles after accept.
- Word 4 = 0x0000000E; SH @0x12 with wdata 0x1234ABCD -> mem_we high for exactly one cycle (the WR cycle); word 4 becomes 0xABCD000E; resp_valid 3 cycles after accept.
- SW @0x22 with the macro defined -> resp_err=1, mem_we never asserted, word 8 unchanged. Same stimulus without the macro -> word 8 becomes wdata, resp_err=0.
- LW @0x190 (word 100) -> resp_err=1; funct3=011 load @0x0 -> resp_err=1.
- resp_ready held low for 5 cycles in RESP -> resp_valid/rdata stable and req_ready=0 throughout; after the handshake, a new request is accepted on the next cycle.
- rst_n pulsed low during the WR cycle of SB @0x4 (wdata 0xFF) -> mem_we falls immediately, word 1 unchanged, outputs at reset values, next request served normally.
